// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: matches a programmable PAT_W-bit pattern on a 1-bit
// stream with overlap control, a sample qualifier and a saturating match counter.
module seq_pattern_detector #(
  parameter int PAT_W = 4,   // legal range 2..16
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             x_in,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pattern_in,
  input  logic             overlap,
  input  logic             clear_cnt,
  output logic             y_out,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_PRE   = CNT_MAX - 1'b1;

  logic [PAT_W-1:0]  pattern_reg, pattern_next;
  logic [PAT_W-2:0]  hist_reg, hist_next;
  logic [FILL_W-1:0] fill_reg, fill_next;
  logic [CNT_W-1:0]  match_cnt_reg, match_cnt_next;
  logic              cnt_sat_reg, cnt_sat_next;

  logic              accept;
  logic              match;
  logic [PAT_W-1:0]  cand;
  logic [PAT_W-1:0]  bit_eq;

  // Oldest history bit lands in the MSB; the live bit lines up with pattern[0].
  assign cand   = {hist_reg, x_in};
  assign accept = en & ~pat_load;

  for (genvar gi = 0; gi < PAT_W; gi++) begin : g_cmp
    assign bit_eq[gi] = cand[gi] ~^ pattern_reg[gi];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pattern_reg   <= '1;
      hist_reg      <= '0;
      fill_reg      <= '0;
      match_cnt_reg <= '0;
      cnt_sat_reg   <= 1'b0;
    end else begin
      pattern_reg   <= pattern_next;
      hist_reg      <= hist_next;
      fill_reg      <= fill_next;
      match_cnt_reg <= match_cnt_next;
      cnt_sat_reg   <= cnt_sat_next;
    end
  end

  // Next-state logic
  always_comb begin
    pattern_next   = pattern_reg;
    hist_next      = hist_reg;
    fill_next      = fill_reg;
    match_cnt_next = match_cnt_reg;
    cnt_sat_next   = cnt_sat_reg;

    if (pat_load) begin
      pattern_next = pattern_in;
      hist_next    = '0;
      fill_next    = '0;
    end else if (accept) begin
      if (match && !overlap) begin
        // Non-overlapping: the next match must be built from fresh bits.
        hist_next = '0;
        fill_next = '0;
      end else begin
        hist_next = cand[PAT_W-2:0];
        if (fill_reg != FILL_FULL) begin
          fill_next = fill_reg + 1'b1;
        end
      end
    end

    if (clear_cnt) begin
      match_cnt_next = '0;
      cnt_sat_next   = 1'b0;
    end else if (match && (match_cnt_reg != CNT_MAX)) begin
      match_cnt_next = match_cnt_reg + 1'b1;
      if (match_cnt_reg == CNT_PRE) begin
        cnt_sat_next = 1'b1;
      end
    end
  end

  // Output logic (Mealy)
  always_comb begin
    match = accept & (fill_reg == FILL_FULL) & (&bit_eq);
    y_out = match & ~rst;
  end

  assign match_cnt = match_cnt_reg;
  assign cnt_sat   = cnt_sat_reg;

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Randomised and directed checks of seq_pattern_detector against a queue-based
// reference model of the accepted bit stream.
module tb_seq_pattern_detector;

  localparam int PAT_W = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             x_in;
  logic             pat_load;
  logic [PAT_W-1:0] pattern_in;
  logic             overlap;
  logic             clear_cnt;
  logic             y_out;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  int pass_cnt  = 0;
  int total_cnt = 0;

  seq_pattern_detector #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .x_in(x_in), .pat_load(pat_load),
    .pattern_in(pattern_in), .overlap(overlap), .clear_cnt(clear_cnt),
    .y_out(y_out), .match_cnt(match_cnt), .cnt_sat(cnt_sat)
  );

  always #5 clk = ~clk;

  // Reference model: accepted bits since the last reset / pat_load / non-overlap match.
  bit [PAT_W-1:0] m_pat;
  bit             m_q[$];
  int             m_cnt;
  bit             m_sat;

  task automatic check(input string tag, input int obs, input int exp);
    total_cnt++;
    if (obs == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic bit m_match(input bit e, input bit pl, input bit x);
    bit [PAT_W-1:0] w;
    int n;
    if (!e || pl) return 1'b0;
    n = m_q.size();
    if (n < PAT_W - 1) return 1'b0;
    w = '0;
    for (int k = n - (PAT_W - 1); k < n; k++) w = {w[PAT_W-2:0], m_q[k]};
    w = {w[PAT_W-2:0], x};
    return w == m_pat;
  endfunction

  function automatic void m_reset();
    m_pat = '1;
    m_q.delete();
    m_cnt = 0;
    m_sat = 1'b0;
  endfunction

  // One clock cycle: drive, check the Mealy output, clock, check registered state.
  task automatic cyc(input bit e, input bit x, input bit ov, input bit pl,
                     input bit [PAT_W-1:0] p, input bit clr, output bit yo);
    bit exp_y;
    en = e; x_in = x; overlap = ov; pat_load = pl; pattern_in = p; clear_cnt = clr;
    #2;
    exp_y = m_match(e, pl, x);
    check("y_out", int'(y_out), int'(exp_y));
    yo = y_out;
    @(posedge clk);
    if (pl) begin
      m_pat = p;
      m_q.delete();
    end else if (e) begin
      if (exp_y && !ov) m_q.delete();
      else begin
        m_q.push_back(x);
        if (m_q.size() > PAT_W) void'(m_q.pop_front());
      end
    end
    if (clr) begin
      m_cnt = 0;
      m_sat = 1'b0;
    end else if (exp_y && m_cnt < CMAX) begin
      m_cnt++;
      if (m_cnt == CMAX) m_sat = 1'b1;
    end
    #1;
    check("match_cnt", int'(match_cnt), m_cnt);
    check("cnt_sat", int'(cnt_sat), int'(m_sat));
    $display("t=%0t en=%0b x=%0b ov=%0b pl=%0b clr=%0b y=%0b cnt=%0d sat=%0b",
             $time, e, x, ov, pl, clr, yo, match_cnt, cnt_sat);
  endtask

  // Run a stream of bits with en=1 and collect y_out (first bit ends up in the MSB).
  task automatic run_bits(input int n, input bit [31:0] bits, input bit ov, output bit [31:0] ys);
    bit yo;
    ys = '0;
    for (int i = n - 1; i >= 0; i--) begin
      cyc(1'b1, bits[i], ov, 1'b0, '0, 1'b0, yo);
      ys = {ys[30:0], yo};
    end
  endtask

  task automatic load(input bit [PAT_W-1:0] p);
    bit yo;
    cyc(1'b1, 1'b1, 1'b1, 1'b1, p, 1'b0, yo);
    check("pat_load_y", int'(yo), 0);
  endtask

  task automatic clr_cnt();
    bit yo;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, yo);
  endtask

  task automatic pulse_reset();
    rst = 1'b1; en = 1'b1; x_in = 1'b1; pat_load = 1'b0; clear_cnt = 1'b0;
    #2;
    m_reset();
    check("rst_y", int'(y_out), 0);
    check("rst_cnt", int'(match_cnt), 0);
    check("rst_sat", int'(cnt_sat), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    bit [31:0] ys;
    bit yo;
    rst = 1'b1; en = 1'b0; x_in = 1'b0; pat_load = 1'b0;
    pattern_in = '0; overlap = 1'b1; clear_cnt = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_y", int'(y_out), 0);
    check("reset_cnt", int'(match_cnt), 0);
    check("reset_sat", int'(cnt_sat), 0);
    rst = 1'b0;

    // Default pattern 1111, overlapping
    run_bits(7, 32'b1111111, 1'b1, ys);
    check("ovl_ones_y", int'(ys[6:0]), 7'b0001111);
    check("ovl_ones_cnt", int'(match_cnt), 4);

    // Non-overlapping
    clr_cnt();
    load(4'b1111);
    run_bits(7, 32'b1111111, 1'b0, ys);
    check("novl_ones_y", int'(ys[6:0]), 7'b0001000);
    check("novl_ones_cnt", int'(match_cnt), 1);
    run_bits(1, 32'b1, 1'b0, ys);
    check("novl_8th_y", int'(ys[0]), 1);

    // Pattern 1011, both modes
    load(4'b1011);
    run_bits(7, 32'b1011011, 1'b1, ys);
    check("p1011_ovl_y", int'(ys[6:0]), 7'b0001001);
    load(4'b1011);
    run_bits(7, 32'b1011011, 1'b0, ys);
    check("p1011_novl_y", int'(ys[6:0]), 7'b0001000);

    // en gaps are transparent
    load(4'b1011);
    run_bits(2, 32'b10, 1'b1, ys);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, i[0], 1'b1, 1'b0, '0, 1'b0, yo);
      check("en_gap_y", int'(yo), 0);
    end
    run_bits(2, 32'b11, 1'b1, ys);
    check("en_gap_match", int'(ys[1:0]), 2'b01);

    // Saturation, then clear on a match cycle
    clr_cnt();
    load(4'b1111);
    run_bits(20, 32'hFFFFF, 1'b1, ys);
    check("sat_cnt", int'(match_cnt), CMAX);
    check("sat_flag", int'(cnt_sat), 1);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b1, yo);
    check("clr_on_match_y", int'(yo), 1);
    check("clr_on_match_cnt", int'(match_cnt), 0);

    // Reset mid-sequence
    load(4'b1111);
    run_bits(3, 32'b111, 1'b1, ys);
    pulse_reset();
    run_bits(4, 32'b1111, 1'b1, ys);
    check("post_rst_y", int'(ys[3:0]), 4'b0001);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 1'b0, yo);
    check("pl_blocks_match", int'(yo), 0);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r < 8) pulse_reset();
      else cyc(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 6), 1'($urandom),
               ($urandom_range(0, 99) < 4), PAT_W'($urandom), ($urandom_range(0, 99) < 3), yo);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
